// File: rtl/wb_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter_if
// Purpose : bundles the register-file write-port signals of wb_write_arbiter.
//           This covers the pipeline WB request, the MUL/DIV result handshake,
//           the registered write port and the hazard status outputs.
// Modports:
//   master - producer side (pipeline / MUL/DIV unit / consumers of status)
//   slave  - the arbiter itself
// Signals :
//   pipe_we, pipe_waddr, pipe_wd   pipeline WB write request (never stalled)
//   md_valid, md_ready             MUL/DIV result handshake
//   md_waddr, md_wd                MUL/DIV result payload
//   we, waddr, wd                  register-file write port (registered)
//   pending_mask                   bit r set while a live queued entry targets r
//   q_count                        number of live queued entries
// ---------------------------------------------------------------------------
interface wb_write_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  pipe_we;
  logic [ADDR_W-1:0]     pipe_waddr;
  logic [DATA_W-1:0]     pipe_wd;
  logic                  md_valid;
  logic                  md_ready;
  logic [ADDR_W-1:0]     md_waddr;
  logic [DATA_W-1:0]     md_wd;
  logic                  we;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wd;
  logic [2**ADDR_W-1:0]  pending_mask;
  logic [CNT_W-1:0]      q_count;

  modport master (
    output pipe_we, pipe_waddr, pipe_wd,
    output md_valid, md_waddr, md_wd,
    input  md_ready,
    input  we, waddr, wd, pending_mask, q_count
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wd,
    input  md_valid, md_waddr, md_wd,
    output md_ready,
    output we, waddr, wd, pending_mask, q_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
// Purpose : sole driver of the register-file write port. Pipeline WB writes
//           always take the slot; MUL/DIV results are queued (DEPTH entries)
//           and drained into idle slots in acceptance order. A pipeline write
//           to register r kills any queued entry for r (the younger value
//           wins). pending_mask tells the ID stage which registers still have
//           a queued write outstanding.
// Ports   :
//   clk   in  clock, all state on posedge
//   rst   in  asynchronous active-low reset
//   bus   slave modport of wb_write_arbiter_if (see interface header)
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  wb_write_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Queue storage: slot 0 is always the oldest live entry. Killed entries are
  // squeezed out in the cycle of the kill, so the occupied-slot count and the
  // live count are the same number and md_ready can never overrun storage.
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              md_ready_q, md_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [NREG-1:0]   mask_q, mask_d;

  logic              pipe_act;
  logic              md_keep;
  logic [CNT_W-1:0]  fill;

  // Classify the current pipeline slot and MUL/DIV transfer.
  always_comb begin
    pipe_act = bus.pipe_we && (bus.pipe_waddr != ADDR_W'(0));
    // Results for x0, or for the register the pipeline writes this very
    // cycle, are consumed but never stored.
    md_keep  = bus.md_valid && md_ready_q &&
               (bus.md_waddr != ADDR_W'(0)) &&
               !(pipe_act && (bus.md_waddr == bus.pipe_waddr));
  end

  // Slot arbitration, queue kill/pop/push and next-state status.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
    end
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wd_d    = wd_q;
    fill    = count_q;

    if (pipe_act) begin
      we_d    = 1'b1;
      waddr_d = bus.pipe_waddr;
      wd_d    = bus.pipe_wd;
      // Compact survivors towards slot 0, dropping entries the pipe kills.
      fill = CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < count_q) && (addr_q[i] != bus.pipe_waddr)) begin
          addr_d[fill[PTR_W-1:0]] = addr_q[i];
          data_d[fill[PTR_W-1:0]] = data_q[i];
          fill = fill + CNT_W'(1);
        end else begin
          // empty slot or killed entry: not carried forward
        end
      end
    end else if (count_q != CNT_W'(0)) begin
      // Idle slot: drain the head and shift the rest down.
      we_d    = 1'b1;
      waddr_d = addr_q[0];
      wd_d    = data_q[0];
      for (int i = 0; i < DEPTH - 1; i++) begin
        addr_d[i] = addr_q[i+1];
        data_d[i] = data_q[i+1];
      end
      fill = count_q - CNT_W'(1);
    end else begin
      fill = count_q;
    end

    // New results land behind the survivors, so they drain no earlier than
    // the next idle slot.
    if (md_keep) begin
      addr_d[fill[PTR_W-1:0]] = bus.md_waddr;
      data_d[fill[PTR_W-1:0]] = bus.md_wd;
      fill = fill + CNT_W'(1);
    end else begin
      fill = fill;
    end

    count_d    = fill;
    md_ready_d = (fill < DEPTH_C);

    mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < fill) begin
        mask_d[addr_d[i]] = 1'b1;
      end else begin
        mask_d = mask_d;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      count_q    <= '0;
      md_ready_q <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wd_q       <= '0;
      mask_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
      count_q    <= count_d;
      md_ready_q <= md_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wd_q       <= wd_d;
      mask_q     <= mask_d;
    end
  end

  assign bus.md_ready     = md_ready_q;
  assign bus.we           = we_q;
  assign bus.waddr        = waddr_q;
  assign bus.wd           = wd_q;
  assign bus.pending_mask = mask_q;
  assign bus.q_count      = count_q;

endmodule
